coef_cfg_ctrl: RTL
==================

Name: coef_cfg_ctrl

Overview:
- Configuration controller for the 3x3 filter coefficients (coef1_1..coef3_3) feeding the filter datapath.
- Host writes go into a shadow bank over a simple addressed write port; a commit request is armed and applied to the active bank only at a frame boundary, so a frame is never filtered with a mixed kernel.
- Active bank outputs drive the filter coefficient inputs directly.
- Sits between the host/config bus and the filter, alongside the line-buffer sequencer that supplies frame_end.

Parameters:
- COEF_W, 10, coefficient width in bits.
- IDLE_CYC, 1024, consecutive cycles with data_valid_in low after which the stream is idle and a pending commit applies without frame_end.

Ports:
- clk  in  1  clock.
- aclr  in  1  asynchronous reset, active-low.
- cfg_wr_en  in  1  write strobe, single-cycle per write.
- cfg_addr  in  4  coefficient index, 0..8 = coef1_1,1_2,1_3,2_1,...,3_3 (row-major).
- cfg_wdata  in  COEF_W  write data.
- cfg_commit  in  1  request to apply the shadow bank to the active bank.
- frame_end  in  1  single-cycle pulse from the sequencer at the last pixel of a frame.
- data_valid_in  in  1  input pixel stream valid.
- cfg_wr_ack  out  1  pulses 1 cycle after an accepted write.
- cfg_err  out  1  pulses 1 cycle after a rejected write.
- cfg_busy  out  1  high while a commit is pending.
- coef_update  out  1  pulses in the cycle the active bank takes its new value.
- coef1_1..coef3_3  out  COEF_W each  active coefficients.

Behaviour:
- Reset, asynchronous on aclr low:
  - Active and shadow banks load the identity kernel: coef2_2 = 1, all others = 0.
  - cfg_wr_ack, cfg_err, cfg_busy and coef_update = 0.
  - FSM = IDLE; idle counter = 0.
  - A pending commit is discarded.
- FSM has three states:
  - IDLE: cfg_commit -> PENDING.
  - PENDING: cfg_busy = 1. The transition to SWAP happens on frame_end or when the idle counter reaches IDLE_CYC, whichever comes first.
  - SWAP: one cycle. Active bank <= shadow bank, coef_update = 1. Next state is IDLE.
- Write acceptance:
  - A write is accepted in IDLE when cfg_addr <= 8. The shadow entry updates at the clock edge; cfg_wr_ack pulses the next cycle.
  - cfg_addr 9..15 is rejected: no state change, cfg_err pulses.
  - A write in PENDING or SWAP is rejected: shadow unchanged, cfg_err pulses.
- Write and cfg_commit in the same IDLE cycle: the write is applied first and is included in the commit.
- cfg_commit in PENDING or SWAP is ignored. It is not queued and does not raise an error.
- frame_end in the same cycle as the commit is accepted (IDLE -> PENDING) does not trigger the swap. The swap waits for the next frame_end or the idle timeout.
- Idle counter:
  - Clears whenever data_valid_in = 1 or the FSM is not PENDING.
  - Otherwise increments and saturates at IDLE_CYC.
  - The counter is IDLE_CYC-wide enough (clog2(IDLE_CYC+1)).
- Latency:
  - The active outputs change on the edge ending SWAP, i.e. 2 edges after the qualifying frame_end edge.
  - New coefficients are therefore in effect before the first pixel of the next frame, because the sequencer's frame gap is at least 2 cycles.
- coef_update is asserted in the same cycle as the new active values.
- Coefficients are unsigned COEF_W bits and stored verbatim; no arithmetic is performed.

Optional Feature:
- COEF_READBACK_EN defined:
  - Adds the ports cfg_rd_en (in, 1), cfg_rsel (in, 1; 0 = shadow, 1 = active) and cfg_rdata (out, COEF_W).
  - cfg_rdata is registered and valid 1 cycle after cfg_rd_en. It holds its value otherwise and resets to 0.
  - An address > 8 returns 0 and pulses cfg_err.
  - Reads are allowed in every state.
- COEF_READBACK_EN undefined: those ports and their logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package coef_cfg_pkg holds:
  - the FSM state enum (IDLE, PENDING, SWAP);
  - NUM_COEF = 9 and the address-to-coefficient index constants;
  - the identity-kernel reset constant.
- One sub-module, coef_bank: a 9 x COEF_W register bank with write-enable/address, whole-bank parallel load and an identity reset value. It is instantiated twice, as shadow and active.

Test Plan:
- Reset then read outputs -> coef2_2 = 1, the other eight = 0; busy, ack, err and update = 0.
- Write addr 0..8 with values 11..19, commit, frame_end 5 cycles later:
  - active outputs unchanged until the SWAP edge;
  - then coef1_1 = 11 ... coef3_3 = 19;
  - coef_update pulses exactly once;
  - cfg_busy is high from the cycle after commit until SWAP.
- Write addr 12 -> cfg_err pulses, no ack, shadow unchanged.
- Write during PENDING -> err pulses, and the later swap uses the pre-commit shadow values.
- Commit with frame_end in the same cycle -> no swap on that frame_end; the swap happens on the next frame_end.
- Commit with data_valid_in held low and no frame_end (IDLE_CYC = 16 in the bench) -> swap after 16 idle cycles. A data_valid_in pulse at cycle 10 restarts the count.
- aclr asserted during PENDING -> identity kernel restored, busy = 0, and no swap on a following frame_end.

Source files
------------

// File: rtl/coef_cfg_pkg.sv
// Shared types and constants for the 3x3 coefficient configuration controller.
// Build option COEF_READBACK_EN (see coef_cfg_ctrl) does not affect this package.
package coef_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    SWAP    = 2'd2
  } coef_state_e;

  localparam int NUM_COEF = 9;

  // Row-major host address of each kernel tap.
  localparam logic [3:0] ADDR_C11 = 4'd0;
  localparam logic [3:0] ADDR_C12 = 4'd1;
  localparam logic [3:0] ADDR_C13 = 4'd2;
  localparam logic [3:0] ADDR_C21 = 4'd3;
  localparam logic [3:0] ADDR_C22 = 4'd4;
  localparam logic [3:0] ADDR_C23 = 4'd5;
  localparam logic [3:0] ADDR_C31 = 4'd6;
  localparam logic [3:0] ADDR_C32 = 4'd7;
  localparam logic [3:0] ADDR_C33 = 4'd8;
  localparam logic [3:0] ADDR_MAX = ADDR_C33;

  // Identity kernel: only the centre tap is 1; bit i is the reset value of entry i.
  localparam logic [NUM_COEF-1:0] IDENT_MASK = 9'b0_0001_0000;

  function automatic logic addr_valid(input logic [3:0] addr);
    return addr <= ADDR_MAX;
  endfunction

endpackage

// File: rtl/coef_bank.sv
// Nine-entry coefficient register bank with addressed write, whole-bank load
// and identity-kernel reset. Used for both the shadow and the active bank.
module coef_bank
  import coef_cfg_pkg::*;
#(
  parameter int COEF_W = 10
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              i_wr_en,
  input  logic [3:0]        i_wr_addr,
  input  logic [COEF_W-1:0] i_wr_data,
  input  logic              i_load_en,
  input  logic [COEF_W-1:0] i_load_data [NUM_COEF],
  output logic [COEF_W-1:0] o_coef      [NUM_COEF]
);

  logic [COEF_W-1:0] r_bank [NUM_COEF];

  // Whole-bank load wins over a single-entry write; addresses past the last tap never match.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      for (int i = 0; i < NUM_COEF; i++) r_bank[i] <= COEF_W'(IDENT_MASK[i]);
    end else if (i_load_en) begin
      for (int i = 0; i < NUM_COEF; i++) r_bank[i] <= i_load_data[i];
    end else if (i_wr_en) begin
      for (int i = 0; i < NUM_COEF; i++) begin
        if (i_wr_addr == 4'(i)) r_bank[i] <= i_wr_data;
      end
    end
  end

  assign o_coef = r_bank;

endmodule

// File: rtl/coef_cfg_ctrl.sv
// Double-buffered 3x3 filter coefficient controller: host writes a shadow bank,
// a commit is applied to the active bank only at frame_end or after a stream-idle timeout.
// Optional build macro COEF_READBACK_EN adds a registered read port for either bank.
module coef_cfg_ctrl
  import coef_cfg_pkg::*;
#(
  parameter int COEF_W   = 10,
  parameter int IDLE_CYC = 1024
) (
  input  logic              clk,
  input  logic              aclr,
  input  logic              cfg_wr_en,
  input  logic [3:0]        cfg_addr,
  input  logic [COEF_W-1:0] cfg_wdata,
  input  logic              cfg_commit,
  input  logic              frame_end,
  input  logic              data_valid_in,
  output logic              cfg_wr_ack,
  output logic              cfg_err,
  output logic              cfg_busy,
  output logic              coef_update,
  output logic [COEF_W-1:0] coef1_1,
  output logic [COEF_W-1:0] coef1_2,
  output logic [COEF_W-1:0] coef1_3,
  output logic [COEF_W-1:0] coef2_1,
  output logic [COEF_W-1:0] coef2_2,
  output logic [COEF_W-1:0] coef2_3,
  output logic [COEF_W-1:0] coef3_1,
  output logic [COEF_W-1:0] coef3_2,
  output logic [COEF_W-1:0] coef3_3,
`ifdef COEF_READBACK_EN
  input  logic              cfg_rd_en,
  input  logic              cfg_rsel,
  output logic [COEF_W-1:0] cfg_rdata,
`endif
  output coef_state_e       o_dbg_state
);

  localparam int CNT_W = $clog2(IDLE_CYC + 1);

  // Host interface: a write strobe is a one-cycle request with no back-pressure;
  // it is answered exactly once, one cycle later, by either cfg_wr_ack or cfg_err.
  coef_state_e       r_state;
  coef_state_e       w_next_state;
  logic [CNT_W-1:0]  r_idle_cnt;
  logic              w_idle_done;
  logic              w_wr_ok;
  logic              w_wr_rej;
  logic              w_err;
  logic              w_swap;
  logic              r_cfg_wr_ack;
  logic              r_cfg_err;
  logic              r_coef_update;
  logic [COEF_W-1:0] w_shadow [NUM_COEF];
  logic [COEF_W-1:0] w_active [NUM_COEF];

  assign w_wr_ok     = cfg_wr_en && (r_state == IDLE) && addr_valid(cfg_addr);
  assign w_wr_rej    = cfg_wr_en && !w_wr_ok;
  assign w_swap      = (r_state == SWAP);
  assign w_idle_done = (r_idle_cnt == CNT_W'(IDLE_CYC));

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // frame_end in the commit cycle is not seen: the check only happens once in PENDING.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (cfg_commit) w_next_state = PENDING;
      PENDING: if (frame_end || w_idle_done) w_next_state = SWAP;
      SWAP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_idle_cnt <= '0;
    end else if ((r_state != PENDING) || data_valid_in) begin
      r_idle_cnt <= '0;
    end else if (!w_idle_done) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end

  coef_bank #(.COEF_W(COEF_W)) u_shadow (
    .clk         (clk),
    .aclr        (aclr),
    .i_wr_en     (w_wr_ok),
    .i_wr_addr   (cfg_addr),
    .i_wr_data   (cfg_wdata),
    .i_load_en   (1'b0),
    .i_load_data (w_active),
    .o_coef      (w_shadow)
  );

  coef_bank #(.COEF_W(COEF_W)) u_active (
    .clk         (clk),
    .aclr        (aclr),
    .i_wr_en     (1'b0),
    .i_wr_addr   (cfg_addr),
    .i_wr_data   (cfg_wdata),
    .i_load_en   (w_swap),
    .i_load_data (w_shadow),
    .o_coef      (w_active)
  );

`ifdef COEF_READBACK_EN
  logic              w_rd_rej;
  logic [COEF_W-1:0] w_rd_val;
  logic [COEF_W-1:0] r_cfg_rdata;

  assign w_rd_rej = cfg_rd_en && !addr_valid(cfg_addr);

  always_comb begin
    w_rd_val = '0;
    for (int i = 0; i < NUM_COEF; i++) begin
      if (cfg_addr == 4'(i)) w_rd_val = cfg_rsel ? w_active[i] : w_shadow[i];
    end
  end

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr)          r_cfg_rdata <= '0;
    else if (cfg_rd_en) r_cfg_rdata <= w_rd_val;
  end

  assign cfg_rdata = r_cfg_rdata;
  assign w_err     = w_wr_rej || w_rd_rej;
`else
  assign w_err     = w_wr_rej;
`endif

  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_cfg_wr_ack  <= 1'b0;
      r_cfg_err     <= 1'b0;
      r_coef_update <= 1'b0;
    end else begin
      r_cfg_wr_ack  <= w_wr_ok;
      r_cfg_err     <= w_err;
      r_coef_update <= w_swap;
    end
  end

  assign cfg_wr_ack  = r_cfg_wr_ack;
  assign cfg_err     = r_cfg_err;
  assign coef_update = r_coef_update;
  assign cfg_busy    = (r_state == PENDING);
  assign o_dbg_state = r_state;

  assign coef1_1 = w_active[ADDR_C11];
  assign coef1_2 = w_active[ADDR_C12];
  assign coef1_3 = w_active[ADDR_C13];
  assign coef2_1 = w_active[ADDR_C21];
  assign coef2_2 = w_active[ADDR_C22];
  assign coef2_3 = w_active[ADDR_C23];
  assign coef3_1 = w_active[ADDR_C31];
  assign coef3_2 = w_active[ADDR_C32];
  assign coef3_3 = w_active[ADDR_C33];

endmodule
